// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter:
// read-owner encodings and default widths.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 14;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_WAIT   = 4;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_DATA  = 2'd1,
        OWNER_FETCH = 2'd2
    } owner_e;

    // Width of a counter that must hold 0..max_wait.
    function automatic int cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the memory port arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  upg_mode;

    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic                  ld_gnt;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  stall;

    modport slave (
        input  upg_mode,
        input  ld_req, ld_addr, ld_wdata,
        output ld_gnt,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output stall
    );

    modport master (
        output upg_mode,
        output ld_req, ld_addr, ld_wdata,
        input  ld_gnt,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  stall
    );

endinterface

// File: rtl/mem_port_arbiter_fetch_wait_counter.sv
// Saturating count of consecutive denied fetch cycles;
// at_max promotes fetch over data traffic.
module fetch_wait_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int W = cnt_width(MAX_WAIT);
    localparam logic [W-1:0] CNT_MAX = W'(MAX_WAIT);

    logic [W-1:0] cnt_q;

    assign at_max = (cnt_q == CNT_MAX);

    // Count denied fetch cycles, hold at the limit, clear on grant or idle.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (inc && !at_max) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for loader, CPU data and CPU fetch;
// grants one access per cycle and returns read data a cycle later.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    logic                  at_max;
    logic                  fetch_first;
    logic                  g_ld;
    logic                  g_d;
    logic                  g_if;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] wdata_mux;
    logic                  we_mux;
    owner_e                owner_q;
    owner_e                owner_d;

    assign fetch_first = at_max & bus.if_req;

    // Mutually exclusive grants; reset and loader mode mask the CPU.
    always_comb begin
        g_ld = 1'b0;
        g_d  = 1'b0;
        g_if = 1'b0;
        if (rst_n) begin
            if (bus.upg_mode) begin
                g_ld = bus.ld_req;
            end else begin
                g_if = bus.if_req & (fetch_first | ~bus.d_req);
                g_d  = bus.d_req & ~fetch_first;
            end
        end
    end

    // Route the winner's request onto the RAM port.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        we_mux    = 1'b0;
        unique case (1'b1)
            g_ld: begin
                addr_mux  = bus.ld_addr;
                wdata_mux = bus.ld_wdata;
                we_mux    = 1'b1;
            end
            g_d: begin
                addr_mux  = bus.d_addr;
                wdata_mux = bus.d_wdata;
                we_mux    = bus.d_we;
            end
            g_if: begin
                addr_mux  = bus.if_addr;
            end
            default: ;
        endcase
    end

    assign bus.ld_gnt    = g_ld;
    assign bus.d_gnt     = g_d;
    assign bus.if_gnt    = g_if;
    assign bus.ram_en    = g_ld | g_d | g_if;
    assign bus.ram_we    = we_mux;
    assign bus.ram_addr  = addr_mux;
    assign bus.ram_wdata = wdata_mux;

    assign bus.stall = rst_n &
        ((bus.d_req & ~g_d) | (bus.if_req & ~g_if));

    // Next read owner: only reads leave a response pending.
    always_comb begin
        owner_d = OWNER_NONE;
        if (g_d && !bus.d_we) begin
            owner_d = OWNER_DATA;
        end else if (g_if) begin
            owner_d = OWNER_FETCH;
        end
    end

    // Owner register, reloaded every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= OWNER_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign bus.d_rvalid  = (owner_q == OWNER_DATA);
    assign bus.if_rvalid = (owner_q == OWNER_FETCH);
    assign bus.d_rdata   = bus.ram_rdata;
    assign bus.if_rdata  = bus.ram_rdata;

    fetch_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (bus.if_req & ~g_if),
        .clr    (g_if | ~bus.if_req),
        .at_max (at_max)
    );

endmodule
